hamming74_scrubber: RTL

//  Background scrubber for the Hamming(7,4)-protected 4-bit universal register.

---
 rtl/hamming74_scrubber.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hamming74_scrubber.sv
// Background scrubber for a Hamming(7,4) protected register: samples the stored
// codeword while the register is idle, publishes corrected data and writes single-bit fixes back.
module hamming74_scrubber #(
  parameter int SCRUB_PERIOD = 64,
  parameter int CNT_W        = 8,
  parameter int WB_TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             scrub_req,
  input  logic             reg_busy,
  input  logic [6:0]       cw_in,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [6:0]       wb_cw,
  output logic [3:0]       data_out,
  output logic             data_valid,
  output logic [2:0]       syndrome,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_count,
  output logic             timeout_err,
  output logic [1:0]       state_dbg
);

  localparam int TMR_W = $clog2(SCRUB_PERIOD);
  localparam int WTO_W = $clog2(WB_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SCRUB_PERIOD - 1);
  localparam logic [WTO_W-1:0] WTO_LAST   = WTO_W'(WB_TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SAMPLE = 2'd1;
  localparam logic [1:0] DECODE = 2'd2;
  localparam logic [1:0] WB     = 2'd3;

  logic [1:0]       state;
  logic             pending;
  logic [TMR_W-1:0] timer;
  logic [WTO_W-1:0] wb_tmr;
  logic [6:0]       cw_q;

  logic [2:0] syn;
  logic [7:0] flip_mask;
  logic [6:0] cw_fix;
  logic [3:0] data_fix;
  logic       timer_run;
  logic       timer_fire;
  logic       pend_set;
  logic       cnt_inc;

  assign state_dbg = state;

  // Syndrome equals the 1-based position of the flipped bit; bit 0 of the mask is discarded
  // so a zero syndrome leaves the word untouched.
  always_comb begin
    syn[0]    = cw_q[0] ^ cw_q[2] ^ cw_q[4] ^ cw_q[6];
    syn[1]    = cw_q[1] ^ cw_q[2] ^ cw_q[5] ^ cw_q[6];
    syn[2]    = cw_q[3] ^ cw_q[4] ^ cw_q[5] ^ cw_q[6];
    flip_mask = 8'd1 << syn;
    cw_fix    = cw_q ^ flip_mask[7:1];
    data_fix  = {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
  end

  // Timer only advances while idle and the register is free to be sampled.
  assign timer_run  = en && (state == IDLE) && !reg_busy;
  assign timer_fire = timer_run && (timer == '0);
  assign pend_set   = en && (scrub_req || timer_fire);
  assign cnt_inc    = en && (state == DECODE) && (syn != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= TMR_RELOAD;
    end else if (timer_run) begin
      timer <= (timer == '0) ? TMR_RELOAD : timer - TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      err_count <= '0;
    end else if (cnt_inc && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

  // Handshake: wb_cw is held while wb_valid=1; a word transfers on a rising edge
  // where wb_valid and wb_ready are both high. reg_busy in WB withdraws the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= 1'b0;
      wb_tmr      <= '0;
      cw_q        <= '0;
      wb_valid    <= 1'b0;
      wb_cw       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      syndrome    <= '0;
      err_flag    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        wb_valid <= 1'b0;
        pending  <= 1'b0;
      end else begin
        pending <= pending | pend_set;
        case (state)
          IDLE: begin
            if (pending && !reg_busy) begin
              state   <= SAMPLE;
              pending <= pend_set;
            end
          end
          SAMPLE: begin
            if (reg_busy) begin
              state   <= IDLE;
              pending <= 1'b1;
            end else begin
              cw_q  <= cw_in;
              state <= DECODE;
            end
          end
          DECODE: begin
            syndrome   <= syn;
            err_flag   <= (syn != 3'd0);
            data_out   <= data_fix;
            data_valid <= 1'b1;
            if (syn != 3'd0) begin
              wb_cw    <= cw_fix;
              wb_valid <= 1'b1;
              wb_tmr   <= '0;
              state    <= WB;
            end else begin
              state <= IDLE;
            end
          end
          WB: begin
            if (reg_busy) begin
              wb_valid <= 1'b0;
              pending  <= 1'b1;
              state    <= IDLE;
            end else if (wb_ready) begin
              wb_valid <= 1'b0;
              state    <= IDLE;
            end else if (wb_tmr == WTO_LAST) begin
              wb_valid    <= 1'b0;
              timeout_err <= 1'b1;
              state       <= IDLE;
            end else begin
              wb_tmr <= wb_tmr + WTO_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
